// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle sequencer family.
// Holds the sequencer state encoding, the 4-bit duty type and the period-length helper.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    UP      = 3'd2,
    HOLD_HI = 3'd3,
    DOWN    = 3'd4,
    HOLD_LO = 3'd5
  } seq_state_t;

  typedef logic [3:0] duty_t;

  // Clocks per PWM period; must match the value used by the PWM generator.
  function automatic int unsigned calc_cnt_thresh(input int unsigned clk_freq,
                                                  input int unsigned pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; period_tick marks the last clock of every period.
// The tick is registered, so it is high exactly while the count sits at CNT_THRESH-1.
module pwm_period_timer #(
  parameter int unsigned CNT_THRESH = 32'd200_000,
  parameter int unsigned CNT_WIDTH  = (CNT_THRESH > 32'd1) ? $clog2(CNT_THRESH) : 32'd1
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CNT_THRESH - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(32'd1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 tick_q;
  logic                 tick_d;

  // Next count wraps at the period end; tick is precomputed from the next count.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    tick_d = (cnt_d == CNT_MAX);
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign period_tick = tick_q;

endmodule

// File: rtl/pwm_duty_seq.sv
// Breathing-profile duty sequencer: ramps duty min->max, holds, ramps back, holds again.
// Every duty change lands on the first clock of a PWM period so the generator never glitches.
module pwm_duty_seq
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 32'd200_000_000,
  parameter int unsigned PWM_FREQ     = 32'd1_000,
  parameter int unsigned STEP_PERIODS = 32'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_min,
  input  logic [3:0] cfg_max,
  input  logic [3:0] cfg_hold,
  input  logic       cfg_loop,
  input  logic       stop,
  output logic [3:0] duty_cycle,
  output logic       period_tick,
  output logic       busy,
  output logic       cycle_done,
  output logic       cfg_err
);

  localparam int unsigned CNT_THRESH = calc_cnt_thresh(CLK_FREQ, PWM_FREQ);
  localparam int unsigned CNT_WIDTH  = (CNT_THRESH > 32'd1) ? $clog2(CNT_THRESH) : 32'd1;
  localparam int unsigned STEP_W     = (STEP_PERIODS > 32'd1) ? $clog2(STEP_PERIODS) : 32'd1;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_PERIODS - 32'd1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(32'd1);

  seq_state_t        state_q;
  seq_state_t        state_d;
  duty_t             duty_q;
  duty_t             duty_d;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [3:0]        hold_q;
  logic [3:0]        hold_d;
  duty_t             min_q;
  duty_t             max_q;
  logic [3:0]        hold_cfg_q;
  logic              loop_q;
  logic              stop_pend_q;
  logic              stop_pend_d;
  logic              busy_q;
  logic              ready_q;
  logic              done_q;
  logic              done_d;
  logic              err_q;
  logic              err_d;

  logic              tick_s;
  logic              xfer_s;
  logic              cfg_bad_s;
  logic              latch_s;
  logic              boundary_s;
  logic              hold_end_s;
  logic              flat_s;
  logic              abort_s;
  duty_t             duty_up_s;
  duty_t             duty_dn_s;

  pwm_period_timer #(
    .CNT_THRESH (CNT_THRESH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (tick_s)
  );

  assign xfer_s     = cfg_valid && ready_q;
  assign cfg_bad_s  = (cfg_min > cfg_max);
  assign boundary_s = tick_s && (step_q == STEP_MAX);
  assign hold_end_s = (hold_q == hold_cfg_q);
  assign flat_s     = (min_q == max_q);
  assign duty_up_s  = duty_q + 4'd1;
  assign duty_dn_s  = duty_q - 4'd1;
  // A stop arriving on the tick itself is honoured at that tick rather than a period later.
  assign abort_s    = (state_q != IDLE) && tick_s && (stop_pend_q || stop);

  // Profile FSM: next state, next duty, hold counting and one-cycle pulses.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    latch_s = 1'b0;
    if (abort_s) begin
      state_d = IDLE;
      duty_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = 4'd0;
          if (xfer_s && cfg_bad_s) begin
            err_d = 1'b1;
          end else if (xfer_s) begin
            latch_s = 1'b1;
            state_d = ARM;
          end else begin
            state_d = IDLE;
          end
        end
        ARM: begin
          if (tick_s) begin
            duty_d  = min_q;
            hold_d  = 4'd0;
            state_d = flat_s ? HOLD_HI : UP;
          end else begin
            state_d = ARM;
          end
        end
        UP: begin
          if (boundary_s) begin
            duty_d  = duty_up_s;
            hold_d  = 4'd0;
            state_d = (duty_up_s == max_q) ? HOLD_HI : UP;
          end else begin
            state_d = UP;
          end
        end
        HOLD_HI: begin
          if (boundary_s && hold_end_s) begin
            hold_d = 4'd0;
            if (flat_s) begin
              state_d = HOLD_LO;
            end else begin
              duty_d  = duty_dn_s;
              state_d = (duty_dn_s == min_q) ? HOLD_LO : DOWN;
            end
          end else if (boundary_s) begin
            hold_d = hold_q + 4'd1;
          end else begin
            hold_d = hold_q;
          end
        end
        DOWN: begin
          if (boundary_s) begin
            duty_d  = duty_dn_s;
            hold_d  = 4'd0;
            state_d = (duty_dn_s == min_q) ? HOLD_LO : DOWN;
          end else begin
            state_d = DOWN;
          end
        end
        HOLD_LO: begin
          if (boundary_s && hold_end_s) begin
            done_d = 1'b1;
            hold_d = 4'd0;
            if (!loop_q) begin
              state_d = IDLE;
              duty_d  = 4'd0;
            end else if (flat_s) begin
              state_d = HOLD_HI;
            end else begin
              duty_d  = duty_up_s;
              state_d = (duty_up_s == max_q) ? HOLD_HI : UP;
            end
          end else if (boundary_s) begin
            hold_d = hold_q + 4'd1;
          end else begin
            hold_d = hold_q;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = 4'd0;
        end
      endcase
    end
  end

  // Step counter and stop-pending flag; a config transfer always leaves the flag clear.
  always_comb begin
    step_d      = step_q;
    stop_pend_d = stop_pend_q;
    if ((state_q == IDLE) || (state_q == ARM)) begin
      step_d = '0;
    end else if (tick_s) begin
      step_d = (step_q == STEP_MAX) ? '0 : (step_q + STEP_ONE);
    end else begin
      step_d = step_q;
    end
    if (xfer_s || (state_q == IDLE) || abort_s) begin
      stop_pend_d = 1'b0;
    end else if (stop) begin
      stop_pend_d = 1'b1;
    end else begin
      stop_pend_d = stop_pend_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      duty_q      <= 4'd0;
      step_q      <= '0;
      hold_q      <= 4'd0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= (state_d != IDLE);
      ready_q     <= (state_d == IDLE);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Latched profile configuration, captured on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q      <= 4'd0;
      max_q      <= 4'd0;
      hold_cfg_q <= 4'd0;
      loop_q     <= 1'b0;
    end else if (latch_s) begin
      min_q      <= cfg_min;
      max_q      <= cfg_max;
      hold_cfg_q <= cfg_hold;
      loop_q     <= cfg_loop;
    end else begin
      min_q      <= min_q;
      max_q      <= max_q;
      hold_cfg_q <= hold_cfg_q;
      loop_q     <= loop_q;
    end
  end

  assign duty_cycle  = duty_q;
  assign period_tick = tick_s;
  assign busy        = busy_q;
  assign cfg_ready   = ready_q;
  assign cycle_done  = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq: 16 clocks per period, 2 periods per step.
// Outputs are sampled on the falling edge; expected values are hand-derived constants.
module tb_pwm_duty_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_min = 4'd0;
  logic [3:0] cfg_max = 4'd0;
  logic [3:0] cfg_hold = 4'd0;
  logic       cfg_loop = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] duty_cycle;
  logic       period_tick;
  logic       busy;
  logic       cycle_done;
  logic       cfg_err;

  int n_pass  = 0;
  int n_total = 0;
  int prof [0:8] = '{2, 3, 4, 5, 5, 4, 3, 2, 2};

  pwm_duty_seq #(
    .CLK_FREQ     (32'd1600),
    .PWM_FREQ     (32'd100),
    .STEP_PERIODS (32'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_min     (cfg_min),
    .cfg_max     (cfg_max),
    .cfg_hold    (cfg_hold),
    .cfg_loop    (cfg_loop),
    .stop        (stop),
    .duty_cycle  (duty_cycle),
    .period_tick (period_tick),
    .busy        (busy),
    .cycle_done  (cycle_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one configuration for a single cycle; returns on the falling edge after the transfer edge.
  task automatic send_cfg(input logic [3:0] mn, input logic [3:0] mx,
                          input logic [3:0] hd, input logic lp);
    cfg_min   = mn;
    cfg_max   = mx;
    cfg_hold  = hd;
    cfg_loop  = lp;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Wait (bounded) for the first non-zero duty; reports whether the previous sample had the tick.
  task automatic wait_duty_on(output int found, output int prev_tick);
    found     = 0;
    prev_tick = int'(period_tick);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (duty_cycle != 4'd0) begin
        found = 1;
        break;
      end
      prev_tick = int'(period_tick);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty"},  32'(duty_cycle),  32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_ready"}, 32'(cfg_ready),   32'd1);
    check({tag, "_done"},  32'(cycle_done),  32'd0);
    check({tag, "_err"},   32'(cfg_err),     32'd0);
    check({tag, "_tick"},  32'(period_tick), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int prev_tick;
    int done_cnt;
    int idle_cnt;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single profile 2..5, hold 1, no loop.
    send_cfg(4'd2, 4'd5, 4'd1, 1'b0);
    check("cfg_busy",  32'(busy),      32'd1);
    check("cfg_ready", 32'(cfg_ready), 32'd0);
    wait_duty_on(found, prev_tick);
    check("arm_found",      32'(found),      32'd1);
    check("arm_after_tick", 32'(prev_tick),  32'd1);
    check("arm_duty",       32'(duty_cycle), 32'd2);
    done_cnt = 0;
    for (int i = 1; i <= 289; i++) begin
      @(negedge clk);
      if (i < 288) begin
        if (cycle_done) done_cnt++;
        if ((i % 32 == 0) || (i % 32 == 31)) begin
          check("profile_duty", 32'(duty_cycle), 32'(prof[i / 32]));
        end
        if (i == 287) check("profile_busy_before_end", 32'(busy), 32'd1);
      end else if (i == 288) begin
        check("profile_no_early_done", 32'(done_cnt),   32'd0);
        check("profile_done",          32'(cycle_done), 32'd1);
        check("profile_busy_drop",     32'(busy),       32'd0);
        check("profile_duty_idle",     32'(duty_cycle), 32'd0);
        check("profile_ready",         32'(cfg_ready),  32'd1);
      end else begin
        check("profile_done_single", 32'(cycle_done), 32'd0);
      end
    end

    // Loop wrap, then stop while ramping at duty 4.
    send_cfg(4'd2, 4'd5, 4'd1, 1'b1);
    wait_duty_on(found, prev_tick);
    check("loop_found", 32'(found),      32'd1);
    check("loop_duty",  32'(duty_cycle), 32'd2);
    idle_cnt = 0;
    for (int i = 1; i <= 331; i++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (i == 287) begin
        check("loop_last_lo_duty", 32'(duty_cycle), 32'd2);
        check("loop_last_lo_done", 32'(cycle_done), 32'd0);
      end
      if (i == 288) begin
        check("loop_wrap_duty", 32'(duty_cycle), 32'd3);
        check("loop_wrap_done", 32'(cycle_done), 32'd1);
        check("loop_wrap_busy", 32'(busy),       32'd1);
      end
      if (i == 289) check("loop_done_pulse", 32'(cycle_done), 32'd0);
      if (i == 320) check("loop_up_duty4", 32'(duty_cycle), 32'd4);
      if (i == 330) stop = 1'b1;
      if (i == 331) stop = 1'b0;
    end
    check("loop_no_idle_gap", 32'(idle_cnt), 32'd0);
    found    = 0;
    done_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (cycle_done) done_cnt++;
      if ((duty_cycle == 4'd0) && !busy) begin
        found = 1;
        break;
      end
    end
    check("stop_reached_idle", 32'(found),     32'd1);
    check("stop_no_done",      32'(done_cnt),  32'd0);
    check("stop_ready",        32'(cfg_ready), 32'd1);

    // Flat profile 7..7, hold 0, loop; reset lands in HOLD_HI at offset 130.
    send_cfg(4'd7, 4'd7, 4'd0, 1'b1);
    check("flat_busy",  32'(busy),      32'd1);
    check("flat_ready", 32'(cfg_ready), 32'd0);
    wait_duty_on(found, prev_tick);
    check("flat_found", 32'(found),      32'd1);
    check("flat_duty",  32'(duty_cycle), 32'd7);
    done_cnt = 0;
    for (int i = 1; i <= 131; i++) begin
      @(negedge clk);
      if ((i < 130) && cycle_done) done_cnt++;
      if ((i < 130) && (i % 16 == 0)) check("flat_duty_hold", 32'(duty_cycle), 32'd7);
      if (i == 15) check("flat_tick_high", 32'(period_tick), 32'd1);
      if (i == 16) check("flat_tick_low",  32'(period_tick), 32'd0);
      if (i == 63) check("flat_done_63",   32'(cycle_done),  32'd0);
      if (i == 64) check("flat_done_64",   32'(cycle_done),  32'd1);
      if (i == 128) check("flat_done_128", 32'(cycle_done),  32'd1);
      if (i == 130) rst = 1'b1;
      if (i == 131) check_reset_vals("midrun_reset");
    end
    check("flat_done_count", 32'(done_cnt), 32'd2);
    rst = 1'b0;

    // Rejected configuration min > max.
    send_cfg(4'd9, 4'd4, 4'd0, 1'b0);
    check("bad_err",   32'(cfg_err),   32'd1);
    check("bad_busy",  32'(busy),      32'd0);
    check("bad_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check("bad_err_pulse", 32'(cfg_err),    32'd0);
    check("bad_busy_2",    32'(busy),       32'd0);
    check("bad_ready_2",   32'(cfg_ready),  32'd1);
    check("bad_duty",      32'(duty_cycle), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_duty_seq.md
# pwm_duty_seq

Duty-cycle sequencer for the static PWM generator. It drives the generator's 4-bit duty input with a programmable triangle ("breathing") profile: ramp from a minimum to a maximum, hold, ramp back down, and hold again. All duty changes take effect only at PWM period boundaries, so the generator never sees a mid-period change. It sits between a register or control interface and one PWM instance.

## Interface
- `CLK_FREQ`, default 200_000_000: clock frequency in Hz.
- `PWM_FREQ`, default 1_000: PWM frequency in Hz. Must equal the PWM instance's value.
- `STEP_PERIODS`, default 8: number of PWM periods per sequencer step (≥1).
- Derived constants: `CNT_THRESH = CLK_FREQ/PWM_FREQ` and `CNT_WIDTH = $clog2(CNT_THRESH)`.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  reset. Synchronous and active-high.
- `cfg_valid`  in  1  a configuration is offered.
- `cfg_ready`  out  1  the block can accept a configuration. High only in IDLE.
- `cfg_min`  in  4  lower duty bound.
- `cfg_max`  in  4  upper duty bound.
- `cfg_hold`  in  4  hold length. Each hold lasts `cfg_hold+1` steps.
- `cfg_loop`  in  1  1 = repeat forever, 0 = run one profile.
- `stop`  in  1  single-cycle abort request.
- `duty_cycle`  out  4  to the PWM duty input. Registered.
- `period_tick`  out  1  high on the last clock of each PWM period.
- `busy`  out  1  high when state ≠ IDLE.
- `cycle_done`  out  1  one-cycle pulse at the end of each full profile.
- `cfg_err`  out  1  one-cycle pulse when a configuration is rejected.

## Operation
- **Period counter:** free-running over 0..CNT_THRESH-1. `period_tick` is high when the count is CNT_THRESH-1. Release this block's reset and the PWM reset on the same cycle so their counters stay aligned.
- **Step counter:** 0..STEP_PERIODS-1.
  - Increments on each `period_tick` outside IDLE and ARM.
  - Cleared on entry to UP or HOLD_HI from ARM.
  - A *boundary* is a `period_tick` with step count = STEP_PERIODS-1.
- **Configuration handshake:** a transfer occurs when `cfg_valid && cfg_ready`.
  - If `cfg_min > cfg_max`: `cfg_err` pulses on the next cycle and the block stays in IDLE.
  - Otherwise the config is latched and the state goes to ARM.
- **States and transitions:**
  - **IDLE:** `duty_cycle = 0`.
  - **ARM:** on the next `period_tick`, set duty = min. Go to UP, or to HOLD_HI if min == max.
  - **UP:** at each boundary, duty + 1. If the new duty equals max, go to HOLD_HI.
  - **HOLD_HI:** the hold counter clears on entry and increments at each boundary. At the boundary where hold counter == `cfg_hold`, exit:
    - to DOWN with duty − 1, or
    - to HOLD_LO with duty unchanged if min == max.
    - If the new duty equals min, go straight to HOLD_LO.
  - **DOWN:** at each boundary, duty − 1. If the new duty equals min, go to HOLD_LO.
  - **HOLD_LO:** same hold rule as HOLD_HI. On exit, `cycle_done` pulses, then:
    - if `cfg_loop` = 1: go to UP with duty + 1 (or to HOLD_HI if min == max);
    - if `cfg_loop` = 0: go to IDLE with duty 0.
- **Stop:**
  - A `stop` pulse sets a pending flag.
  - At the next `period_tick` in any non-IDLE state: go to IDLE, duty = 0, flag cleared, and `cycle_done` does not pulse.
  - `stop` in IDLE is ignored.
  - `stop` and a config transfer in the same cycle: the transfer wins and the flag stays clear.
- **Arithmetic:** duty is 4-bit unsigned and never leaves [min, max]. There is no wrap-around because the bound checks happen before the increment or decrement.

## Timing
- **Reset (next edge):**
  - state IDLE;
  - all counters 0;
  - `duty_cycle` 0, `busy` 0, `cycle_done` 0, `cfg_err` 0, `period_tick` 0;
  - `cfg_ready` 1.
  - A mid-run reset aborts immediately.
- **Config latency:** transfer in cycle t → `busy` = 1 and `cfg_ready` = 0 in cycle t+1.
- **Duty and pulse latency:**
  - `duty_cycle` changes in the cycle after the qualifying `period_tick`, i.e. the first clock of the new period.
  - `cycle_done` is asserted in that same cycle.
- **Stop latency:** ≤ CNT_THRESH+1 clocks from `stop` to duty = 0.

## Structure
- Package `pwm_pkg` holds:
  - the state enum `seq_state_t` {IDLE, ARM, UP, HOLD_HI, DOWN, HOLD_LO};
  - a `duty_t` typedef (logic [3:0]);
  - a constant function that computes CNT_THRESH.
- One sub-module: `pwm_period_timer`. It holds the period counter and produces `period_tick`; PWM variants can reuse it.

## Test plan
Common settings: CLK_FREQ = 1600, PWM_FREQ = 100 (16 clocks per period), STEP_PERIODS = 2 (32 clocks per step).

- **Single profile:** config min = 2, max = 5, hold = 1, loop = 0.
  - Required per-step duty sequence: 2, 3, 4, 5, 5, 4, 3, 2, 2, then 0 in IDLE.
  - `cycle_done` is a single pulse, 9 steps (288 clocks) after duty first becomes 2.
  - `busy` drops on the same cycle as `cycle_done`.
- **Loop wrap:** same config with loop = 1.
  - After the HOLD_LO hold ends, duty = 3, `cycle_done` pulses, and there is no IDLE gap.
- **Flat profile:** min = max = 7, hold = 0, loop = 1.
  - Duty stays 7 throughout.
  - `cycle_done` pulses every 2 steps (64 clocks).
- **Bad config:** min = 9, max = 4.
  - `cfg_err` pulses one cycle after the transfer.
  - `busy` stays 0, and `cfg_ready` stays 1.
- **Stop mid-ramp:** pulse `stop` while duty = 4 in UP.
  - Duty = 0 and IDLE within 17 clocks.
  - No `cycle_done`.
  - A new config is then accepted normally.
- **Reset mid-HOLD_HI:** assert `rst` for one cycle.
  - On the next cycle: all outputs at their reset values and `cfg_ready` = 1.
